imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the core's immediate decoder: packs an opcode, register and funct fields, and a 32-bit immediate into a RISC-V RV32I instruction word for the selected format.
- Feeds the boot loader / test-program generator path that writes instruction memory.
- Supports the LI pseudo-instruction, which expands into ADDI or into LUI+ADDI.
- Valid/ready on both sides; one registered output stage.

Parameters:
- NOP_WORD, 32'h0000_0013, word emitted for a reserved format code.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI, 7=reserved.
- in_opcode  in  7  opcode[6:0]; ignored for LI.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R only).
- in_imm  in  32  immediate, byte offset for B/J, full value for U/LI.
- out_valid  out  1  word valid.
- out_ready  in  1  consumer ready.
- out_instr  out  32  encoded instruction.
- out_last  out  1  final word of this request.
- out_err  out  1  immediate out of range/misaligned for the format.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_instr=0, out_last=0, out_err=0, FSM=IDLE. in_ready=1 once reset is released.
- Output register advances when !out_valid || out_ready.
- in_ready = (FSM==IDLE) && (!out_valid || out_ready).
- Latency: request accepted at edge N -> out_valid=1 after edge N. Output holds stable while out_valid && !out_ready.
- Encodings (bit slices of in_imm):
  - R: {f7,rs2,rs1,f3,rd,op}.
  - I: {imm[11:0],rs1,f3,rd,op}.
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - U: {imm[31:12],rd,op}.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Reserved format: out_instr=NOP_WORD, out_err=1, out_last=1.
- Range checks (out_err):
  - I/S: imm[31:11] must be all 0 or all 1.
  - B: imm[31:12] sign-consistent and imm[0]=0.
  - J: imm[31:20] sign-consistent and imm[0]=0.
  - U: imm[11:0]=0.
  - R, LI: never flagged.
  - On error, the word is still encoded from the truncated bits.
- LI FSM (IDLE, LO_PEND):
  - lo = imm[11:0]; hi = (imm + 32'h800) >> 12, 20 bits, wraps modulo 2^32.
  - If imm fits signed 12 bits: emit ADDI rd,x0,lo (op 0x13, f3 0), out_last=1, stay IDLE.
  - Else emit LUI rd,hi (op 0x37), out_last=0, go to LO_PEND.
    - If lo==0: the LUI word has out_last=1 and the FSM stays IDLE.
  - LO_PEND: when the LUI word handshakes, load ADDI rd,rd,lo with out_last=1, then return to IDLE. No input is accepted in LO_PEND.
- Non-LI formats: out_last=1 always.
- Back-to-back: a new request is accepted in the same cycle the previous final word handshakes, giving full throughput.
- Reset mid-LI (in LO_PEND or with a word pending): pending words are discarded; out_valid=0 immediately.
- rd=x0 is not special-cased.

Optional Feature:
- IMM_ENC_RANGE_CHECK_EN.
- Defined: range checks above drive out_err.
- Undefined: out_err tied 0 for all formats except reserved, which still asserts out_err=1. Checking logic is not synthesized; encodings are identical.

Test Plan:
- I, op 0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> out_instr 0xFFF00093, last=1, err=0, one cycle after accept.
- B, op 0x63, rs1=rs2=0, imm=8 -> 0x00000463. Same with imm=3 -> err=1 (bit0 dropped).
- J, op 0x6F, rd=1, imm=0x800 -> 0x001000EF. imm=0x00100000 -> err=1.
- LI, rd=5, imm=0x12345FFF:
  - Words 0x123462B7 (last=0), then 0xFFF28293 (last=1).
  - Hold out_ready=0 for 3 cycles on word 1: out_instr stable, in_ready=0.
- LI, rd=5, imm=0x00010000 -> single word 0x000102B7, last=1. LI imm=-5 -> 0xFFB00293.
- Reset asserted in LO_PEND -> out_valid=0 immediately. After release, a fresh I request encodes correctly with no stale ADDI emitted.

Source files
------------

// File: rtl/imm_encoder.sv
// RV32I instruction encoder with LI pseudo-instruction expansion (ADDI or LUI+ADDI).
// Optional macro IMM_ENC_RANGE_CHECK_EN enables per-format immediate range/alignment flags on out_err.
module imm_encoder #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_last,
   output logic        out_err
);

   localparam logic [2:0] F_R  = 3'd0;
   localparam logic [2:0] F_I  = 3'd1;
   localparam logic [2:0] F_S  = 3'd2;
   localparam logic [2:0] F_B  = 3'd3;
   localparam logic [2:0] F_U  = 3'd4;
   localparam logic [2:0] F_J  = 3'd5;
   localparam logic [2:0] F_LI = 3'd6;

   typedef enum logic {IDLE, LO_PEND} state_t;

   // Handshake: a transfer happens on a rising edge where valid && ready on that side.
   state_t      state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        out_last_q, out_last_d;
   logic        out_err_q, out_err_d;
   logic [31:0] pend_word_q, pend_word_d;

   logic        advance;
   logic        fits12;
   logic [31:0] li_sum;
   logic [31:0] enc_instr;
   logic [31:0] enc_lo_word;
   logic        enc_last;
   logic        enc_pend;
   logic        enc_err;
   logic        rc_err;

   assign advance   = !out_valid_q || out_ready;
   assign in_ready  = (state_q == IDLE) && advance;
   assign fits12    = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign li_sum    = in_imm + 32'h0000_0800;

`ifdef IMM_ENC_RANGE_CHECK_EN
   logic b_ok, j_ok, u_ok;
   assign b_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
   assign j_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
   assign u_ok = !(|in_imm[11:0]);

   always_comb begin
      rc_err = 1'b0;
      case (in_fmt)
         F_I, F_S: rc_err = !fits12;
         F_B:      rc_err = !b_ok;
         F_U:      rc_err = !u_ok;
         F_J:      rc_err = !j_ok;
         default:  rc_err = 1'b0;
      endcase
   end
`else
   assign rc_err = 1'b0;
`endif

   always_comb begin
      enc_instr   = NOP_WORD;
      enc_last    = 1'b1;
      enc_pend    = 1'b0;
      enc_err     = (in_fmt == 3'd7) || rc_err;
      // Second half of a LUI+ADDI expansion: ADDI rd,rd,lo.
      enc_lo_word = {in_imm[11:0], in_rd, 3'b000, in_rd, 7'h13};
      case (in_fmt)
         F_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         F_I: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         F_S: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         F_B: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
         F_U: enc_instr = {in_imm[31:12], in_rd, in_opcode};
         F_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
         F_LI: begin
            if (fits12) begin
               enc_instr = {in_imm[11:0], 5'd0, 3'b000, in_rd, 7'h13};
            end else begin
               // hi is rounded so that the sign-extended lo ADDI lands on the exact value.
               enc_instr = {li_sum[31:12], in_rd, 7'h37};
               if (in_imm[11:0] != 12'd0) begin
                  enc_last = 1'b0;
                  enc_pend = 1'b1;
               end
            end
         end
         default: enc_instr = NOP_WORD;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_last_d  = out_last_q;
      out_err_d   = out_err_q;
      pend_word_d = pend_word_q;
      if (advance) begin
         if (state_q == LO_PEND) begin
            out_valid_d = 1'b1;
            out_instr_d = pend_word_q;
            out_last_d  = 1'b1;
            out_err_d   = 1'b0;
            state_d     = IDLE;
         end else if (in_valid) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_last_d  = enc_last;
            out_err_d   = enc_err;
            if (enc_pend) begin
               state_d     = LO_PEND;
               pend_word_d = enc_lo_word;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'd0;
         out_last_q  <= 1'b0;
         out_err_q   <= 1'b0;
         pend_word_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_last_q  <= out_last_d;
         out_err_q   <= out_err_d;
         pend_word_q <= pend_word_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_last  = out_last_q;
   assign out_err   = out_err_q;

endmodule
